// File: rtl/capture_sched.sv
// capture_sched: round-robin owner of a shared capture timer issuing periodic capture bursts
// Ports: clk, reset (sync, active-high); req[NREQ] level requests; req_period/req_count packed
// per-requester PW/CW fields; grant one-hot owner; capture/done single-cycle strobes;
// aborted qualifies done; busy high outside IDLE.
// Define CAPTURE_SCHED_ABORT_EN to end a burst early when the granted req drops during RUN.
module capture_sched #(
  parameter int NREQ = 4,
  parameter int PW = 16,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*PW-1:0] req_period,
  input  logic [NREQ*CW-1:0] req_count,
  output logic [NREQ-1:0]   grant,
  output logic              capture,
  output logic              done,
  output logic              aborted,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, gidx, sel, j;
  logic [PW-1:0] cnt, per, p_in;
  logic [CW-1:0] rem, c_in;
  logic ab, drop, last, found;
  always_comb begin
    sel = rr_ptr;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
  end
  assign p_in = req_period[sel*PW +: PW];
  assign c_in = req_count[sel*CW +: CW];
  assign capture = (state == RUN) && (cnt == per - PW'(1));
  assign last = capture && (rem == CW'(1));
`ifdef CAPTURE_SCHED_ABORT_EN
  assign drop = (state == RUN) && !req[gidx];
`else
  assign drop = 1'b0;
`endif
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign aborted = done && ab;
  assign grant = busy ? NREQ'(1) << gidx : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gidx <= '0;
      cnt <= '0;
      per <= '0;
      rem <= '0;
      ab <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gidx <= sel;
          per <= p_in < PW'(2) ? PW'(2) : p_in;
          rem <= c_in;
          cnt <= '0;
          ab <= 1'b0;
          state <= c_in == '0 ? FIN : RUN;
        end
        RUN: begin
          cnt <= capture ? '0 : cnt + 1'b1;
          rem <= capture ? rem - 1'b1 : rem;
          // a drop on the final capture still counts as a normal completion
          ab <= drop && !last;
          state <= (drop || last) ? FIN : RUN;
        end
        FIN: begin
          state <= IDLE;
          rr_ptr <= gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_sched.sv
// tb_capture_sched: scoreboard bench for capture_sched
module tb_capture_sched;
  localparam int NREQ = 4, PW = 16, CW = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*PW-1:0] req_period = '0;
  logic [NREQ*CW-1:0] req_count = '0;
  logic [NREQ-1:0] grant;
  logic capture, done, aborted, busy;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int c; logic d; logic [NREQ-1:0] g; logic a;} ev_t;
  ev_t q[$];

  capture_sched #(.NREQ(NREQ), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_period(req_period), .req_count(req_count),
    .grant(grant), .capture(capture), .done(done), .aborted(aborted), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (capture || done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d capture=%b done=%b grant=%b aborted=%b", cyc, capture, done, grant, aborted);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (cyc !== e.c || done !== e.d || capture !== !e.d || grant !== e.g || aborted !== e.a) begin
          errors++;
          $display("FAIL event got cyc=%0d cap=%b done=%b grant=%b ab=%b, want cyc=%0d done=%b grant=%b ab=%b",
                   cyc, capture, done, grant, aborted, e.c, e.d, e.g, e.a);
        end
      end
    end
  end

  task automatic cfg(input int i, input int p, input int c);
    req_period[i*PW +: PW] = PW'(p);
    req_count[i*CW +: CW] = CW'(c);
  endtask

  task automatic push_burst(input int i, input int c0, input int p, input int n, input int stop_after);
    int pe = p < 2 ? 2 : p;
    int nc = (stop_after > 0 && stop_after < n) ? stop_after : n;
    logic [NREQ-1:0] g = NREQ'(1) << i;
    for (int k = 0; k < nc; k++) q.push_back('{c0 + pe * (k + 1), 1'b0, g, 1'b0});
    q.push_back('{c0 + pe * nc + 1, 1'b1, g, nc != n});
  endtask

  task automatic wait_done(input string name, input int ndone, input int bound);
    int seen = 0;
    for (int t = 0; t < bound && seen < ndone; t++) begin
      @(negedge clk);
      if (done) seen++;
    end
    req = '0;
    checks++;
    if (seen < ndone) begin
      errors++;
      $display("FAIL %s_timeout dones=%0d want %0d", name, seen, ndone);
    end
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle grant=%b busy=%b want 0000/0", name, grant, busy);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing pending=%0d want 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, capture, done, aborted, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {grant, capture, done, aborted, busy});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c0;
    cfg(0, 5, 3);
    @(negedge clk);
    req = 4'b0001;
    c0 = cyc;
    push_burst(0, c0, 5, 3, 0);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant grant=%b busy=%b want 0001/1", grant, busy);
    end
    cfg(0, 2, 9);
    wait_done("basic", 1, 40);
  endtask

  task automatic test_clamp();
    int c0;
    for (int p = 0; p < 3; p++) begin
      cfg(1, p, 2);
      @(negedge clk);
      req = 4'b0010;
      c0 = cyc;
      push_burst(1, c0, p, 2, 0);
      wait_done("clamp", 1, 20);
    end
  endtask

  task automatic test_count0();
    int c0;
    cfg(3, 7, 0);
    @(negedge clk);
    req = 4'b1000;
    c0 = cyc;
    push_burst(3, c0, 7, 0, 0);
    wait_done("count0", 1, 10);
  endtask

  task automatic test_back_to_back();
    int c0;
    test_reset();
    for (int i = 0; i < NREQ; i++) cfg(i, 2, 1);
    @(negedge clk);
    req = 4'b1111;
    c0 = cyc;
    for (int k = 0; k < 5; k++) push_burst(k % NREQ, c0 + 4 * k, 2, 1, 0);
    wait_done("b2b", 5, 40);
  endtask

  task automatic test_abort();
    int c0, t;
    cfg(1, 10, 4);
    @(negedge clk);
    req = 4'b0010;
    c0 = cyc;
`ifdef CAPTURE_SCHED_ABORT_EN
    push_burst(1, c0, 10, 4, 1);
`else
    push_burst(1, c0, 10, 4, 0);
`endif
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!capture && t < 20);
    req = '0;
    wait_done("abort", 1, 60);
  endtask

  task automatic test_reset_mid();
    int c0;
    cfg(2, 5, 3);
    @(negedge clk);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_run busy=%b grant=%b want 1/0100", busy, grant);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear busy=%b grant=%b done=%b want 0/0000/0", busy, grant, done);
    end
    reset = 1'b0;
    cfg(1, 2, 1);
    req = 4'b1110;
    c0 = cyc;
    push_burst(1, c0, 2, 1, 0);
    for (int t = 0; t < 10 && !done; t++) @(negedge clk);
    req = '0;
    wait_done("rstmid", 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_count0();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
